// File: rtl/inst_fetch_decode.sv
// ============================================================================
// Module   : inst_fetch_decode
// Purpose  : Byte-serial instruction fetch and length decoder feeding the ALU
//            through a valid/ready handshake. Optional macro
//            FETCH_ILLEGAL_TRAP_EN enables the unknown-opcode trap (HALT).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] ope,
    output logic [7:0]  ext_byte,
    output logic [3:0]  num_of_ope,
    output logic [31:0] ope_pc,
    output logic        ope_valid,
    input  logic        ope_ready,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_cnt;
    logic [3:0]  r_len;
    logic [31:0] r_ope;
    logic [7:0]  r_ext;
    logic        r_valid;
    logic        r_mem_rd;
    logic [31:0] r_mem_addr;

    logic [3:0]  w_len_dec;
    logic [3:0]  w_len_cur;
    logic [3:0]  w_cnt_inc;
    logic        w_last;
    logic [31:0] w_pc_next;
    logic [31:0] w_addr_next_byte;

    // Length from the first opcode byte; anything unrecognised is one byte.
    always_comb begin
        w_len_dec = 4'd1;
        case (mem_rdata)
            8'h55, 8'h5d, 8'hc3, 8'hc9: w_len_dec = 4'd1;
            8'h89, 8'h6a:               w_len_dec = 4'd2;
            8'h8b, 8'h83:               w_len_dec = 4'd3;
            8'hb8, 8'he8:               w_len_dec = 4'd5;
            default:                    w_len_dec = 4'd1;
        endcase
    end

    assign w_cnt_inc        = {1'b0, r_cnt} + 4'd1;
    assign w_len_cur        = (r_cnt == 3'd0) ? w_len_dec : r_len;
    assign w_last           = (w_cnt_inc == w_len_cur);
    assign w_pc_next        = r_pc + {28'd0, r_len};
    assign w_addr_next_byte = r_pc + {28'd0, w_cnt_inc};

`ifdef FETCH_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_unknown;

    assign w_unknown = !(mem_rdata inside {8'h55, 8'h5d, 8'hc3, 8'hc9,
                                           8'h89, 8'h6a, 8'h8b, 8'h83,
                                           8'hb8, 8'he8});
    assign illegal   = r_illegal;
`else
    assign illegal   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_cnt      <= 3'd0;
            r_len      <= 4'd0;
            r_ope      <= 32'd0;
            r_ext      <= 8'd0;
            r_valid    <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= 32'd0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            r_mem_rd <= 1'b0;
            if (jump) begin
                // Redirect wins over everything; a read already in flight is
                // simply never captured because WAIT is not entered for it.
                r_pc    <= jump_addr;
                r_cnt   <= 3'd0;
                r_len   <= 4'd0;
                r_ope   <= 32'd0;
                r_ext   <= 8'd0;
                r_valid <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
                r_illegal <= 1'b0;
`endif
                if (run) begin
                    r_state    <= S_REQ;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= jump_addr;
                end else begin
                    r_state    <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run) begin
                            r_state    <= S_REQ;
                            r_cnt      <= 3'd0;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_pc;
                        end
                    end
                    S_REQ: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        case (r_cnt)
                            3'd0:    r_ope[31:24] <= mem_rdata;
                            3'd1:    r_ope[23:16] <= mem_rdata;
                            3'd2:    r_ope[15:8]  <= mem_rdata;
                            3'd3:    r_ope[7:0]   <= mem_rdata;
                            default: r_ext        <= mem_rdata;
                        endcase
                        if (r_cnt == 3'd0) begin
                            r_len <= w_len_dec;
`ifdef FETCH_ILLEGAL_TRAP_EN
                            r_illegal <= w_unknown;
`endif
                        end
                        if (w_last) begin
                            r_state <= S_OUT;
                            r_valid <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_cnt      <= w_cnt_inc[2:0];
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= w_addr_next_byte;
                        end
                    end
                    S_OUT: begin
                        if (ope_ready) begin
                            r_valid <= 1'b0;
                            r_pc    <= w_pc_next;
                            r_cnt   <= 3'd0;
                            r_len   <= 4'd0;
                            r_ope   <= 32'd0;
                            r_ext   <= 8'd0;
`ifdef FETCH_ILLEGAL_TRAP_EN
                            if (r_illegal) begin
                                r_state <= S_HALT;
                            end else
`endif
                            if (run) begin
                                r_state    <= S_REQ;
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= w_pc_next;
                            end else begin
                                r_state    <= S_IDLE;
                            end
                        end
                    end
                    S_HALT: begin
                        r_state <= S_HALT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign ope        = r_ope;
    assign ext_byte   = r_ext;
    assign num_of_ope = r_len;
    assign ope_pc     = r_pc;
    assign ope_valid  = r_valid;

endmodule

`default_nettype wire
